// File: rtl/spi_flash_rdid_responder_if.sv
// SPI pin bundle plus the command/status side-band of the RDID responder.
// The master modport is the SPI master (or bench) side; the slave modport is
// the flash-side responder. status_in exists only when SPI_RESPONDER_RDSR_EN
// is defined.
interface spi_flash_rdid_responder_if;
  logic       cs_n;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic       cmd_valid;
  logic [7:0] cmd_opcode;
  logic       rdid_done;
  logic       busy;
`ifdef SPI_RESPONDER_RDSR_EN
  logic [7:0] status_in;
`endif

  modport master (
`ifdef SPI_RESPONDER_RDSR_EN
    output status_in,
`endif
    output cs_n, sck, mosi,
    input  miso, miso_oe, cmd_valid, cmd_opcode, rdid_done, busy
  );

  modport slave (
`ifdef SPI_RESPONDER_RDSR_EN
    input  status_in,
`endif
    input  cs_n, sck, mosi,
    output miso, miso_oe, cmd_valid, cmd_opcode, rdid_done, busy
  );
endinterface

// File: rtl/spi_flash_rdid_responder.sv
// SPI mode-0 flash-side responder for the RDID (0x9F) command.
// cs_n/sck/mosi are oversampled on clk, the opcode is captured MSB first and,
// on RDID, the JEDEC ID is shifted out on miso (repeating while sck runs).
// Optional feature macro: SPI_RESPONDER_RDSR_EN adds opcode 0x05, which
// streams status_in (resampled at every byte boundary) instead of the ID.
module spi_flash_rdid_responder #(
  parameter logic [23:0] JEDEC_ID    = 24'hC22018,
  parameter logic [7:0]  RDID_OPCODE = 8'h9F,
  parameter int          SYNC_STAGES = 2   // 2 or 3
) (
  input logic                         clk,
  input logic                         reset,
  spi_flash_rdid_responder_if.slave   bus
);

  localparam logic [4:0] ID_LAST = 5'd23;
`ifdef SPI_RESPONDER_RDSR_EN
  localparam logic [7:0] RDSR_OPCODE = 8'h05;
  localparam logic [4:0] SR_LAST     = 5'd7;
`endif

  typedef enum logic [2:0] {
    IDLE,
    RX_CMD,
    TX_ID,
`ifdef SPI_RESPONDER_RDSR_EN
    TX_SR,
`endif
    IGNORE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   cs_d;
  logic                   sck_d;
  logic [2:0]             bit_cnt;
  logic [6:0]             op_shift;
  logic [4:0]             tx_cnt;
  logic [23:0]            tx_shift;
  logic                   miso_q;
  logic                   miso_oe_q;
  logic                   cmd_valid_q;
  logic [7:0]             cmd_opcode_q;
  logic                   rdid_done_q;
  logic                   busy_q;

  logic       cs_s, sck_s, mosi_s;
  logic       sck_rise, sck_fall, cs_fall, cs_rise;
  logic [7:0] op_next;

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise =  sck_s & ~sck_d;
  assign sck_fall = ~sck_s &  sck_d;
  assign cs_fall  = ~cs_s  &  cs_d;
  assign cs_rise  =  cs_s  & ~cs_d;
  assign op_next  = {op_shift, mosi_s};

  // Pin synchronizers and edge-detect delay flops. Deliberately not reset so
  // that a reset taken while cs_n is low cannot fabricate a cs_n fall: the
  // block only re-arms on a genuine high-to-low transition of the pin.
  always_ff @(posedge clk) begin
    cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
    sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
    cs_d      <= cs_s;
    sck_d     <= sck_s;
  end

  // Transaction FSM: opcode capture, ID/status shifting, abort on cs_n rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      op_shift     <= 7'd0;
      tx_cnt       <= 5'd0;
      tx_shift     <= 24'd0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_opcode_q <= 8'h00;
      rdid_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      rdid_done_q <= 1'b0;
      busy_q      <= ~cs_s;
      if (cs_rise) begin
        state     <= IDLE;
        miso_q    <= 1'b0;
        miso_oe_q <= 1'b0;
        bit_cnt   <= 3'd0;
        tx_cnt    <= 5'd0;
      end else begin
        case (state)
          IDLE: begin
            bit_cnt  <= 3'd0;
            op_shift <= 7'd0;
            if (cs_fall) state <= RX_CMD;
          end
          RX_CMD: begin
            if (sck_rise) begin
              op_shift <= op_next[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                cmd_opcode_q <= op_next;
                cmd_valid_q  <= 1'b1;
                if (op_next == RDID_OPCODE) begin
                  state     <= TX_ID;
                  tx_cnt    <= ID_LAST;
                  tx_shift  <= JEDEC_ID;
                  miso_oe_q <= 1'b1;
`ifdef SPI_RESPONDER_RDSR_EN
                end else if (op_next == RDSR_OPCODE) begin
                  state     <= TX_SR;
                  tx_cnt    <= SR_LAST;
                  tx_shift  <= {bus.status_in, 16'h0000};
                  miso_oe_q <= 1'b1;
`endif
                end else begin
                  state <= IGNORE;
                end
              end
            end
          end
          TX_ID: begin
            miso_oe_q <= 1'b1;
            if (sck_fall) begin
              miso_q <= tx_shift[23];
              if (tx_cnt == 5'd0) begin
                tx_shift    <= JEDEC_ID;
                tx_cnt      <= ID_LAST;
                rdid_done_q <= 1'b1;
              end else begin
                tx_shift <= {tx_shift[22:0], 1'b0};
                tx_cnt   <= tx_cnt - 5'd1;
              end
            end
          end
`ifdef SPI_RESPONDER_RDSR_EN
          TX_SR: begin
            miso_oe_q <= 1'b1;
            if (sck_fall) begin
              miso_q <= tx_shift[23];
              if (tx_cnt == 5'd0) begin
                tx_shift <= {bus.status_in, 16'h0000};
                tx_cnt   <= SR_LAST;
              end else begin
                tx_shift <= {tx_shift[22:0], 1'b0};
                tx_cnt   <= tx_cnt - 5'd1;
              end
            end
          end
`endif
          IGNORE: begin
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.miso       = miso_q;
  assign bus.miso_oe    = miso_oe_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.cmd_opcode = cmd_opcode_q;
  assign bus.rdid_done  = rdid_done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_spi_flash_rdid_responder.sv
// Bench for spi_flash_rdid_responder: drives SPI mode-0 transactions and
// compares against a transaction-level reference model of the responder.
// Honours SPI_RESPONDER_RDSR_EN for the status-read opcode.
module tb_spi_flash_rdid_responder;

  localparam logic [23:0] JEDEC = 24'hC22018;
  localparam int          SYNC  = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  spi_flash_rdid_responder_if bus();

  spi_flash_rdid_responder #(
    .JEDEC_ID   (JEDEC),
    .RDID_OPCODE(8'h9F),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int         checks = 0;
  int         errors = 0;
  int         cvCount = 0;
  int         doneCount = 0;
  logic [7:0] lastOp = 8'h00;

  // Pulse monitor: counts cmd_valid / rdid_done and records the opcode.
  always @(negedge clk) begin
    if (bus.cmd_valid) begin
      cvCount++;
      lastOp = bus.cmd_opcode;
    end
    if (bus.rdid_done) doneCount++;
  end

  // Watchdog so the run always ends.
  initial begin
    #700000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: what a master sees for a transaction of nSck full sck
  // cycles with opcode op. Bits are those sampled on rises 9..nSck.
  function automatic void model(input logic [7:0] op, input int nSck, input logic [7:0] st,
                                output logic [63:0] data, output logic [63:0] oeMask,
                                output int cv, output int done);
    logic [23:0] id;
    logic [7:0]  sr;
    bit          isId, isSr, b;
    id = JEDEC;
    sr = st;
    isId = (op == 8'h9F);
`ifdef SPI_RESPONDER_RDSR_EN
    isSr = (op == 8'h05);
`else
    isSr = 1'b0;
`endif
    data = '0;
    oeMask = '0;
    cv = (nSck >= 8) ? 1 : 0;
    for (int k = 9; k <= nSck; k++) begin
      int idx;
      idx = k - 9;
      if (isId)      b = id[23 - (idx % 24)];
      else if (isSr) b = sr[7 - (idx % 8)];
      else           b = 1'b0;
      data   = {data[62:0], b};
      oeMask = {oeMask[62:0], isId | isSr};
    end
    // One ID bit is driven on the fall after each rise from the 8th onward.
    done = (isId && nSck >= 8) ? (nSck - 7) / 24 : 0;
  endfunction

  task automatic applyStimulus(input string name, input logic [7:0] op, input int nSck,
                               input int half, input logic [7:0] st);
    logic [63:0] obsData, obsOe, expData, expOe;
    int          cv0, dn0, expCv, expDone;
`ifdef SPI_RESPONDER_RDSR_EN
    bus.status_in = st;
`endif
    cv0 = cvCount;
    dn0 = doneCount;
    obsData = '0;
    obsOe = '0;
    bus.cs_n = 1'b0;
    waitClk(half);
    checkOutput({name, " busy"}, 64'(bus.busy), 64'd1);
    for (int k = 1; k <= nSck; k++) begin
      bus.mosi = (k <= 8) ? op[8-k] : 1'($urandom_range(0, 1));
      waitClk(half);
      if (k > 8) begin
        obsData = {obsData[62:0], bus.miso};
        obsOe   = {obsOe[62:0], bus.miso_oe};
      end
      bus.sck = 1'b1;
      waitClk(half);
      bus.sck = 1'b0;
    end
    waitClk(half);
    bus.cs_n = 1'b1;
    waitClk(SYNC + 2);
    checkOutput({name, " oe_after_cs"}, 64'(bus.miso_oe), 64'd0);
    checkOutput({name, " miso_after_cs"}, 64'(bus.miso), 64'd0);
    checkOutput({name, " busy_after_cs"}, 64'(bus.busy), 64'd0);
    model(op, nSck, st, expData, expOe, expCv, expDone);
    checkOutput({name, " cmd_valid_cnt"}, 64'(cvCount - cv0), 64'(expCv));
    if (expCv != 0) checkOutput({name, " cmd_opcode"}, 64'(lastOp), 64'(op));
    checkOutput({name, " data"}, obsData, expData);
    checkOutput({name, " miso_oe"}, obsOe, expOe);
    checkOutput({name, " rdid_done_cnt"}, 64'(doneCount - dn0), 64'(expDone));
    waitClk(3);
  endtask

  initial begin
    int cv0;
    logic oeSeen;
    bus.cs_n = 1'b1;
    bus.sck  = 1'b0;
    bus.mosi = 1'b0;
`ifdef SPI_RESPONDER_RDSR_EN
    bus.status_in = 8'h00;
`endif
    reset = 1'b1;
    waitClk(3);
    checkOutput("reset miso", 64'(bus.miso), 64'd0);
    checkOutput("reset miso_oe", 64'(bus.miso_oe), 64'd0);
    checkOutput("reset cmd_valid", 64'(bus.cmd_valid), 64'd0);
    checkOutput("reset cmd_opcode", 64'(bus.cmd_opcode), 64'd0);
    checkOutput("reset rdid_done", 64'(bus.rdid_done), 64'd0);
    checkOutput("reset busy", 64'(bus.busy), 64'd0);
    reset = 1'b0;
    waitClk(4);

    applyStimulus("rdid32", 8'h9F, 32, 10, 8'h00);
    applyStimulus("read03", 8'h03, 32, 10, 8'h00);
    applyStimulus("rdid56", 8'h9F, 56, 10, 8'h00);
    applyStimulus("abort_op5", 8'h9F, 5, 8, 8'h00);
    applyStimulus("abort_id12", 8'h9F, 20, 8, 8'h00);
    applyStimulus("rdid_clean", 8'h9F, 32, 6, 8'h00);
    applyStimulus("rdsr16", 8'h05, 24, 10, 8'hA5);

    // Reset in the middle of an ID read, then keep clocking with cs_n low:
    // nothing may respond until a fresh cs_n fall.
    bus.cs_n = 1'b0;
    waitClk(6);
    for (int k = 1; k <= 12; k++) begin
      bus.mosi = (k <= 8) ? ((8'h9F >> (8 - k)) & 8'h01) != 0 : 1'b0;
      waitClk(6);
      bus.sck = 1'b1;
      waitClk(6);
      bus.sck = 1'b0;
    end
    reset = 1'b1;
    waitClk(2);
    checkOutput("midreset miso_oe", 64'(bus.miso_oe), 64'd0);
    checkOutput("midreset busy", 64'(bus.busy), 64'd0);
    checkOutput("midreset cmd_opcode", 64'(bus.cmd_opcode), 64'd0);
    reset = 1'b0;
    cv0 = cvCount;
    oeSeen = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      bus.mosi = 1'b1;
      waitClk(6);
      oeSeen |= bus.miso_oe;
      bus.sck = 1'b1;
      waitClk(6);
      bus.sck = 1'b0;
    end
    checkOutput("midreset no_cmd", 64'(cvCount - cv0), 64'd0);
    checkOutput("midreset no_oe", 64'(oeSeen), 64'd0);
    bus.cs_n = 1'b1;
    waitClk(6);
    applyStimulus("after_reset_rdid", 8'h9F, 32, 7, 8'h00);

    // Randomized transactions.
    for (int t = 0; t < 24; t++) begin
      logic [7:0] op;
      int         sel;
      sel = $urandom_range(0, 3);
      if (sel <= 1)      op = 8'h9F;
      else if (sel == 2) op = 8'h05;
      else               op = 8'($urandom_range(0, 255));
      applyStimulus("rand", op, $urandom_range(0, 60), $urandom_range(5, 9),
                    8'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
